// File: rtl/dir_wb.sv
// Writeback stage behind DIRQ. A small FIFO absorbs issue bursts and arbitrates
// for a PRF write port, then emits one registered completion per popped entry.
module dir_wb #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_dwb,
    input  logic        ready_awake,
    input  logic [31:0] imm_awake,
    input  logic [5:0]  Pd_awake,
    input  logic        RegWr_awake,
    input  logic [3:0]  Conf_awake,
    input  logic [5:0]  tag_rob_awake,
    input  logic        isJIRL_awake,
    output logic        hold_dirq,
    output logic        wb_req,
    output logic [5:0]  wb_Pd,
    output logic [31:0] wb_data,
    input  logic        wb_grant,
    output logic        done_valid,
    output logic [5:0]  done_tag_rob,
    output logic [5:0]  done_Pd,
    output logic        done_RegWr,
    output logic [3:0]  done_Conf,
    output logic        done_isJIRL,
    output logic        overflow_err
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] imm;
        logic [5:0]  pd;
        logic        regwr;
        logic [3:0]  conf;
        logic [5:0]  tag;
        logic        jirl;
    } ent_t;

    ent_t          mem_q [DEPTH];
    ent_t          mem_d [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    ent_t          done_q, done_d;
    logic          done_v_q, done_v_d;

    ent_t head, in_ent;
    logic empty, full, pop_ok, push_ok;

    always_comb begin
        head    = mem_q[head_q];
        in_ent  = '{imm: imm_awake, pd: Pd_awake, regwr: RegWr_awake, conf: Conf_awake,
                    tag: tag_rob_awake, jirl: isJIRL_awake};
        empty   = (count_q == '0);
        full    = (count_q == (AW+1)'(DEPTH));
        // RegWr=0 entries need no port and drain without waiting for grant
        pop_ok  = !empty && (!head.regwr || wb_grant);
        push_ok = ready_awake && (!full || pop_ok);

        mem_d    = mem_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        done_d   = '0;
        done_v_d = 1'b0;

        if (flush_dwb) begin
            for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop_ok) begin
                head_d   = head_q + 1'b1;
                done_d   = head;
                done_v_d = 1'b1;
            end
            if (push_ok) begin
                mem_d[tail_q] = in_ent;
                tail_d        = tail_q + 1'b1;
            end
            count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
            if (ready_awake && full && !pop_ok) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            done_q   <= '0;
            done_v_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            done_v_q <= done_v_d;
        end
    end

    // One slot of slack covers the bundle DIRQ already has in flight
    assign hold_dirq    = (count_q >= (AW+1)'(DEPTH - 1));
    assign wb_req       = !empty && head.regwr;
    assign wb_Pd        = empty ? 6'd0 : head.pd;
    assign wb_data      = empty ? 32'd0 : head.imm;
    assign done_valid   = done_v_q;
    assign done_tag_rob = done_q.tag;
    assign done_Pd      = done_q.pd;
    assign done_RegWr   = done_q.regwr;
    assign done_Conf    = done_q.conf;
    assign done_isJIRL  = done_q.jirl;
    assign overflow_err = ovf_q;
endmodule
